// File: rtl/vip_src_arbiter.sv
// Frame-granularity round-robin arbiter in front of the shared RGB565->YCbCr converter.
// Forwards one source's frame, drains the converter latency, then reports size status.
module vip_src_arbiter #(
    parameter int H_ACT    = 640,
    parameter int V_ACT    = 480,
    parameter int CNT_W    = 12,
    parameter int PIPE_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        src0_req,
    input  logic        src0_vsync,
    input  logic        src0_hsync,
    input  logic        src0_de,
    input  logic [15:0] src0_data,
    input  logic        src1_req,
    input  logic        src1_vsync,
    input  logic        src1_hsync,
    input  logic        src1_de,
    input  logic [15:0] src1_data,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_de,
    output logic [4:0]  out_red,
    output logic [5:0]  out_green,
    output logic [4:0]  out_blue,
    output logic        frame_done,
    output logic        frame_err,
    output logic        frame_src
);

    localparam int                 DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   H_EXP      = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0]   V_EXP      = CNT_W'(V_ACT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sel;
    logic               w_sel_next;
    logic               r_last_grant;
    logic               w_last_next;
    logic               w_start;
    logic               w_pass;
    logic               w_drain_done;

    logic [1:0]         w_req;
    logic [1:0]         w_vs;
    logic [1:0]         w_hs;
    logic [1:0]         w_de;
    logic [15:0]        w_data [2];
    logic               r_vs_d [2];

    logic               w_sel_vs;
    logic               w_sel_hs;
    logic               w_sel_de;
    logic [15:0]        w_sel_data;
    logic               w_sof;
    logic               w_eof;

    logic               r_out_vs;
    logic               r_out_hs;
    logic               r_out_de;
    logic [15:0]        r_out_data;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic [CNT_W-1:0]   w_pix_next;
    logic [CNT_W-1:0]   r_line_cnt;
    logic [CNT_W-1:0]   w_line_next;
    logic               r_err;
    logic               w_err_next;
    logic               w_de_fall;
    logic               r_frame_done;
    logic               r_frame_err;
    logic               r_frame_src;

    assign w_req     = {src1_req, src0_req};
    assign w_vs      = {src1_vsync, src0_vsync};
    assign w_hs      = {src1_hsync, src0_hsync};
    assign w_de      = {src1_de, src0_de};
    assign w_data[0] = src0_data;
    assign w_data[1] = src1_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vs_d
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vs_d[gi] <= 1'b0;
                end else begin
                    r_vs_d[gi] <= w_vs[gi];
                end
            end
        end
    endgenerate

    assign w_sel_vs   = w_vs[r_sel];
    assign w_sel_hs   = w_hs[r_sel];
    assign w_sel_de   = w_de[r_sel];
    assign w_sel_data = w_data[r_sel];
    assign w_sof      = r_vs_d[r_sel] & ~w_sel_vs;
    assign w_eof      = ~r_vs_d[r_sel] & w_sel_vs;

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_last_next  = r_last_grant;
        w_start      = 1'b0;
        w_pass       = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req[0] ^ w_req[1]) begin
                    w_sel_next = w_req[1];
                    w_start    = 1'b1;
                end else if (&w_req) begin
                    w_sel_next = ~r_last_grant;
                    w_start    = 1'b1;
                end
                if (w_start) begin
                    w_state_next = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                // SOF takes priority over a request drop in the same cycle
                if (w_sof) begin
                    w_pass       = 1'b1;
                    w_state_next = S_ACTIVE;
                end else if (!w_req[r_sel]) begin
                    w_state_next = S_IDLE;
                end
            end
            S_ACTIVE: begin
                w_pass = 1'b1;
                if (w_eof) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_drain_done = 1'b1;
                    w_last_next  = r_sel;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_sel        <= w_sel_next;
            r_last_grant <= w_last_next;
        end
    end

    // r_out_de holds the previous passed de, so it doubles as the edge reference
    always_comb begin
        w_de_fall   = r_out_de & ~w_sel_de;
        w_pix_next  = r_pix_cnt;
        w_line_next = r_line_cnt;
        w_err_next  = r_err;
        if (w_de_fall) begin
            w_pix_next = '0;
            if (r_pix_cnt != H_EXP) begin
                w_err_next = 1'b1;
            end
            if (r_line_cnt != CNT_MAX) begin
                w_line_next = r_line_cnt + 1'b1;
            end
        end else if (w_sel_de && (r_pix_cnt != CNT_MAX)) begin
            w_pix_next = r_pix_cnt + 1'b1;
        end
        if ((r_state == S_ACTIVE) && w_eof && ((w_line_next != V_EXP) || w_sel_de)) begin
            w_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vs     <= 1'b0;
            r_out_hs     <= 1'b0;
            r_out_de     <= 1'b0;
            r_out_data   <= '0;
            r_drain_cnt  <= '0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_src  <= 1'b0;
        end else begin
            if (w_pass) begin
                r_out_vs   <= w_sel_vs;
                r_out_hs   <= w_sel_hs;
                r_out_de   <= w_sel_de;
                r_out_data <= w_sel_data;
            end else begin
                r_out_vs   <= 1'b0;
                r_out_hs   <= 1'b0;
                r_out_de   <= 1'b0;
                r_out_data <= '0;
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end

            if (w_start) begin
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
                r_err      <= 1'b0;
            end else if (w_pass) begin
                r_pix_cnt  <= w_pix_next;
                r_line_cnt <= w_line_next;
                r_err      <= w_err_next;
            end

            r_frame_done <= w_drain_done;
            if (w_drain_done) begin
                r_frame_err <= r_err;
                r_frame_src <= r_sel;
            end
        end
    end

    assign grant      = (r_state == S_IDLE) ? 2'b00 : (r_sel ? 2'b10 : 2'b01);
    assign busy       = (r_state != S_IDLE);
    assign out_vsync  = r_out_vs;
    assign out_hsync  = r_out_hs;
    assign out_de     = r_out_de;
    assign out_red    = r_out_data[15:11];
    assign out_green  = r_out_data[10:5];
    assign out_blue   = r_out_data[4:0];
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign frame_src  = r_frame_src;

endmodule

// File: tb/tb_vip_src_arbiter.sv
// Bench for vip_src_arbiter: random frames on both sources, frame-level reference model,
// per-cycle comparison of every output plus scenario-level expectations.
module tb_vip_src_arbiter;

    localparam int H_ACT    = 8;
    localparam int V_ACT    = 4;
    localparam int CNT_W    = 12;
    localparam int PIPE_LAT = 3;
    localparam int MAXN     = 1023;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [15:0] d;
    } smp_t;

    typedef struct packed {
        logic [1:0] gnt;
        logic       busy;
        smp_t       o;
        logic       done;
        logic       ferr;
        logic       fsrc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        src0_req, src0_vsync, src0_hsync, src0_de;
    logic [15:0] src0_data;
    logic        src1_req, src1_vsync, src1_hsync, src1_de;
    logic [15:0] src1_data;
    logic [1:0]  grant;
    logic        busy, out_vsync, out_hsync, out_de;
    logic [4:0]  out_red;
    logic [5:0]  out_green;
    logic [4:0]  out_blue;
    logic        frame_done, frame_err, frame_src;

    int checks = 0;
    int errors = 0;

    smp_t       s0_q[$];
    smp_t       s1_q[$];
    bit         r0_q[$];
    bit         r1_q[$];
    bit         tail0, tail1;
    obs_t       obs_a [0:MAXN];
    obs_t       exp_a [0:MAXN];
    logic [1:0] obs_done_q[$];
    int         m_first_sof;

    vip_src_arbiter #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src0_req(src0_req), .src0_vsync(src0_vsync), .src0_hsync(src0_hsync),
        .src0_de(src0_de), .src0_data(src0_data),
        .src1_req(src1_req), .src1_vsync(src1_vsync), .src1_hsync(src1_hsync),
        .src1_de(src1_de), .src1_data(src1_data),
        .grant(grant), .busy(busy),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .frame_done(frame_done), .frame_err(frame_err), .frame_src(frame_src)
    );

    initial forever #5 clk = ~clk;

    // ---------------- stimulus timelines ----------------
    function automatic smp_t gs(int s, int k);
        smp_t pad;
        pad    = '0;
        pad.vs = 1'b1;
        if (k < 0) return '0;
        if (s == 0) return (k < s0_q.size()) ? s0_q[k] : pad;
        return (k < s1_q.size()) ? s1_q[k] : pad;
    endfunction

    function automatic bit greq(int s, int k);
        if (s == 0) return (k < r0_q.size()) ? r0_q[k] : tail0;
        return (k < r1_q.size()) ? r1_q[k] : tail1;
    endfunction

    function automatic bit is_sof(int s, int k);
        smp_t a, b;
        a = gs(s, k - 1);
        b = gs(s, k);
        return a.vs && !b.vs;
    endfunction

    function automatic bit is_eof(int s, int k);
        smp_t a, b;
        a = gs(s, k - 1);
        b = gs(s, k);
        return !a.vs && b.vs;
    endfunction

    function automatic int stim_len();
        int m;
        m = s0_q.size();
        if (s1_q.size() > m) m = s1_q.size();
        if (r0_q.size() > m) m = r0_q.size();
        if (r1_q.size() > m) m = r1_q.size();
        m = m + 40;
        return (m > MAXN) ? MAXN : m;
    endfunction

    task automatic clear_stim();
        s0_q.delete(); s1_q.delete(); r0_q.delete(); r1_q.delete();
        tail0 = 1'b0;
        tail1 = 1'b0;
    endtask

    task automatic push(int s, logic vs, logic hs, logic de);
        smp_t x;
        x.vs = vs; x.hs = hs; x.de = de; x.d = 16'($urandom);
        if (s == 0) s0_q.push_back(x);
        else        s1_q.push_back(x);
    endtask

    // vblank, nlines x (2 hblank + de run), one trailing blank, then the EOF sample
    task automatic add_frame(int s, int nlines, int bad_line, int bad_len, bit late_de);
        int vb = 6 + int'($urandom_range(0, 4));
        for (int i = 0; i < vb; i++) push(s, 1'b1, 1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            int len = (l == bad_line) ? bad_len : H_ACT;
            push(s, 1'b0, 1'b1, 1'b0);
            push(s, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < len; i++) push(s, 1'b0, 1'b0, 1'b1);
        end
        push(s, 1'b0, 1'b0, 1'b0);
        push(s, 1'b1, 1'b0, late_de);
    endtask

    // ---------------- frame-level reference model ----------------
    task automatic model_run(int n);
        int t, u, e, d, s, lines, cnt;
        bit found, r0, r1, last, err, prev_de;
        smp_t x;
        for (int k = 0; k <= n; k++) exp_a[k] = '0;
        t = 0; last = 1'b1; m_first_sof = -1;
        while (t <= n) begin
            r0 = greq(0, t);
            r1 = greq(1, t);
            if (!r0 && !r1) begin t++; continue; end
            s = (r0 && r1) ? (last ? 0 : 1) : (r1 ? 1 : 0);
            found = 1'b0;
            u = t + 1;
            while (u <= n) begin
                if (is_sof(s, u)) begin found = 1'b1; break; end
                if (!greq(s, u)) break;
                u++;
            end
            if (!found) begin
                for (int k = t + 1; k <= u && k <= n; k++) begin
                    exp_a[k].gnt  = (s == 1) ? 2'b10 : 2'b01;
                    exp_a[k].busy = 1'b1;
                end
                t = u + 1;
                continue;
            end
            if (m_first_sof < 0) m_first_sof = u;
            e = u + 1;
            while (e <= n && !is_eof(s, e)) e++;
            d = e + PIPE_LAT + 1;
            for (int k = t + 1; k < d && k <= n; k++) begin
                exp_a[k].gnt  = (s == 1) ? 2'b10 : 2'b01;
                exp_a[k].busy = 1'b1;
            end
            cnt = 0; lines = 0; err = 1'b0; prev_de = 1'b0;
            for (int k = u; k <= e; k++) begin
                x = gs(s, k);
                if (k + 1 <= n) exp_a[k + 1].o = x;
                if (x.de) cnt++;
                else if (prev_de) begin
                    if (cnt != H_ACT) err = 1'b1;
                    lines++;
                    cnt = 0;
                end
                prev_de = x.de;
            end
            if (lines != V_ACT || prev_de) err = 1'b1;
            if (d <= n) begin
                exp_a[d].done = 1'b1;
                exp_a[d].ferr = err;
                exp_a[d].fsrc = (s == 1);
            end
            last = (s == 1);
            t = d;
        end
        for (int k = 1; k <= n; k++) begin
            if (!exp_a[k].done) begin
                exp_a[k].ferr = exp_a[k - 1].ferr;
                exp_a[k].fsrc = exp_a[k - 1].fsrc;
            end
        end
    endtask

    // ---------------- drive / record ----------------
    task automatic drive_idle();
        src0_req = 0; src0_vsync = 0; src0_hsync = 0; src0_de = 0; src0_data = '0;
        src1_req = 0; src1_vsync = 0; src1_hsync = 0; src1_de = 0; src1_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_sim(int n);
        smp_t a, b;
        obs_done_q.delete();
        for (int k = 0; k <= n; k++) begin
            obs_a[k] = {grant, busy, out_vsync, out_hsync, out_de, out_red, out_green,
                        out_blue, frame_done, frame_err, frame_src};
            if (frame_done) obs_done_q.push_back({frame_src, frame_err});
            if (k == n) break;
            a = gs(0, k);
            b = gs(1, k);
            src0_req = greq(0, k); src0_vsync = a.vs; src0_hsync = a.hs;
            src0_de  = a.de;       src0_data  = a.d;
            src1_req = greq(1, k); src1_vsync = b.vs; src1_hsync = b.hs;
            src1_de  = b.de;       src1_data  = b.d;
            @(negedge clk);
        end
        drive_idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({grant, busy, out_vsync, out_hsync, out_de, out_red, out_green, out_blue,
             frame_done, frame_err, frame_src} !== 25'd0) begin
            errors++;
            $display("FAIL reset_values: got grant=%b busy=%b vs=%b de=%b done=%b err=%b src=%b, expected all 0",
                     grant, busy, out_vsync, out_de, frame_done, frame_err, frame_src);
        end
        rst_n = 1'b1;
        src0_req = 1'b1;
        src1_req = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_tie: got grant=%b, expected 01", grant);
        end
        drive_idle();
        $display("test_reset done");
    endtask

    task automatic test_src0_only();
        int n, k_eof, k_done;
        clear_stim();
        tail0 = 1'b1;
        add_frame(0, V_ACT, -1, 0, 1'b0);
        add_frame(0, V_ACT, -1, 0, 1'b0);
        add_frame(1, V_ACT, -1, 0, 1'b0);
        add_frame(1, V_ACT, -1, 0, 1'b0);
        n = stim_len();
        do_reset();
        model_run(n);
        run_sim(n);
        for (int k = 0; k <= n; k++) begin
            checks++;
            if (obs_a[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL src0_only cycle %0d: got %h, expected %h", k, obs_a[k], exp_a[k]);
            end
        end
        checks++;
        if (obs_done_q.size() < 1 || obs_done_q[0] !== 2'b00) begin
            errors++;
            $display("FAIL src0_only_status: got %0d frames first={src,err}=%b, expected 00",
                     obs_done_q.size(), (obs_done_q.size() > 0) ? obs_done_q[0] : 2'bxx);
        end
        k_eof = -1; k_done = -1;
        for (int k = 1; k <= n; k++) begin
            if (k_eof < 0 && obs_a[k].o.vs && !obs_a[k - 1].o.vs) k_eof = k;
            if (k_done < 0 && obs_a[k].done) k_done = k;
        end
        checks++;
        if (k_eof < 0 || k_done < 0 || (k_done - k_eof) != PIPE_LAT) begin
            errors++;
            $display("FAIL src0_done_latency: got eof@%0d done@%0d, expected distance %0d",
                     k_eof, k_done, PIPE_LAT);
        end
        $display("test_src0_only done: %0d cycles, %0d frames", n, obs_done_q.size());
    endtask

    task automatic test_alternate();
        int n;
        logic [1:0] want [4];
        want[0] = 2'b00; want[1] = 2'b10; want[2] = 2'b00; want[3] = 2'b10;
        clear_stim();
        tail0 = 1'b1;
        tail1 = 1'b1;
        for (int f = 0; f < 10; f++) begin
            add_frame(0, V_ACT, -1, 0, 1'b0);
            add_frame(1, V_ACT, -1, 0, 1'b0);
        end
        n = stim_len();
        do_reset();
        model_run(n);
        run_sim(n);
        for (int k = 0; k <= n; k++) begin
            checks++;
            if (obs_a[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL alternate cycle %0d: got %h, expected %h", k, obs_a[k], exp_a[k]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_done_q.size() <= i || obs_done_q[i] !== want[i]) begin
                errors++;
                $display("FAIL alternate_order frame %0d: got {src,err}=%b, expected %b", i,
                         (obs_done_q.size() > i) ? obs_done_q[i] : 2'bxx, want[i]);
            end
        end
        $display("test_alternate done: %0d cycles, %0d frames", n, obs_done_q.size());
    endtask

    task automatic test_bad_line();
        int n;
        clear_stim();
        tail0 = 1'b1;
        add_frame(0, V_ACT, 2, H_ACT - 1, 1'b0);
        add_frame(0, V_ACT, -1, 0, 1'b0);
        n = stim_len();
        do_reset();
        model_run(n);
        run_sim(n);
        for (int k = 0; k <= n; k++) begin
            checks++;
            if (obs_a[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL bad_line cycle %0d: got %h, expected %h", k, obs_a[k], exp_a[k]);
            end
        end
        checks++;
        if (obs_done_q.size() != 2 || obs_done_q[0] !== 2'b01 || obs_done_q[1] !== 2'b00) begin
            errors++;
            $display("FAIL bad_line_status: got %0d frames first=%b second=%b, expected 01 then 00",
                     obs_done_q.size(), (obs_done_q.size() > 0) ? obs_done_q[0] : 2'bxx,
                     (obs_done_q.size() > 1) ? obs_done_q[1] : 2'bxx);
        end
        $display("test_bad_line done: %0d cycles", n);
    endtask

    task automatic test_req_drop();
        int n;
        bit src0_seen;
        clear_stim();
        for (int i = 0; i < 6; i++) r0_q.push_back(1'b1);
        tail1 = 1'b1;
        for (int i = 0; i < 14; i++) push(0, 1'b1, 1'b0, 1'b0);
        add_frame(0, V_ACT, -1, 0, 1'b0);
        add_frame(1, V_ACT, -1, 0, 1'b0);
        add_frame(1, V_ACT, -1, 0, 1'b0);
        add_frame(1, V_ACT, -1, 0, 1'b0);
        n = stim_len();
        do_reset();
        model_run(n);
        run_sim(n);
        for (int k = 0; k <= n; k++) begin
            checks++;
            if (obs_a[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL req_drop cycle %0d: got %h, expected %h", k, obs_a[k], exp_a[k]);
            end
        end
        src0_seen = 1'b0;
        foreach (obs_done_q[i]) if (obs_done_q[i][1] == 1'b0) src0_seen = 1'b1;
        checks++;
        if (obs_done_q.size() < 1 || src0_seen || obs_done_q[0] !== 2'b10) begin
            errors++;
            $display("FAIL req_drop_status: got %0d frames first=%b src0_frame=%b, expected src1 frames only",
                     obs_done_q.size(), (obs_done_q.size() > 0) ? obs_done_q[0] : 2'bxx, src0_seen);
        end
        $display("test_req_drop done: %0d cycles", n);
    endtask

    task automatic test_extra_lines_late_de();
        int n;
        clear_stim();
        tail0 = 1'b1;
        add_frame(0, V_ACT + 1, -1, 0, 1'b0);
        add_frame(0, V_ACT, -1, 0, 1'b1);
        n = stim_len();
        do_reset();
        model_run(n);
        run_sim(n);
        for (int k = 0; k <= n; k++) begin
            checks++;
            if (obs_a[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL extra_late cycle %0d: got %h, expected %h", k, obs_a[k], exp_a[k]);
            end
        end
        checks++;
        if (obs_done_q.size() != 2 || obs_done_q[0] !== 2'b01 || obs_done_q[1] !== 2'b01) begin
            errors++;
            $display("FAIL extra_late_status: got %0d frames first=%b second=%b, expected 01 then 01",
                     obs_done_q.size(), (obs_done_q.size() > 0) ? obs_done_q[0] : 2'bxx,
                     (obs_done_q.size() > 1) ? obs_done_q[1] : 2'bxx);
        end
        $display("test_extra_lines_late_de done: %0d cycles", n);
    endtask

    task automatic test_reset_mid_frame();
        int n, np;
        clear_stim();
        tail0 = 1'b1;
        tail1 = 1'b1;
        add_frame(0, V_ACT, -1, 0, 1'b0);
        add_frame(1, V_ACT, -1, 0, 1'b0);
        n = stim_len();
        do_reset();
        model_run(n);
        np = (m_first_sof < 0) ? 20 : m_first_sof + 15;
        run_sim(np);
        for (int k = 0; k <= np; k++) begin
            checks++;
            if (obs_a[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL reset_mid_pre cycle %0d: got %h, expected %h", k, obs_a[k], exp_a[k]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, busy, out_vsync, out_hsync, out_de, out_red, out_green, out_blue,
             frame_done, frame_err, frame_src} !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got grant=%b busy=%b vs=%b de=%b data=%h done=%b, expected all 0",
                     grant, busy, out_vsync, out_de, {out_red, out_green, out_blue}, frame_done);
        end
        clear_stim();
        tail0 = 1'b1;
        tail1 = 1'b1;
        add_frame(0, V_ACT, -1, 0, 1'b0);
        add_frame(1, V_ACT, -1, 0, 1'b0);
        add_frame(0, V_ACT, -1, 0, 1'b0);
        add_frame(1, V_ACT, -1, 0, 1'b0);
        n = stim_len();
        @(negedge clk);
        do_reset();
        model_run(n);
        run_sim(n);
        for (int k = 0; k <= n; k++) begin
            checks++;
            if (obs_a[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL reset_mid_post cycle %0d: got %h, expected %h", k, obs_a[k], exp_a[k]);
            end
        end
        checks++;
        if (obs_done_q.size() < 1 || obs_done_q[0] !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_tie: got %0d frames first={src,err}=%b, expected 00",
                     obs_done_q.size(), (obs_done_q.size() > 0) ? obs_done_q[0] : 2'bxx);
        end
        $display("test_reset_mid_frame done: %0d cycles", n);
    endtask

    initial begin
        drive_idle();
        clear_stim();
        @(negedge clk);
        test_reset();
        test_src0_only();
        test_alternate();
        test_bad_line();
        test_req_drop();
        test_extra_lines_late_de();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vip_src_arbiter.md
Name: vip_src_arbiter

Overview:
- Frame-granularity arbiter sharing the single RGB565→YCbCr conversion pipeline between two RGB565 video sources on the same clock.
- Grants one source per frame, round-robin.
- Passes the granted source's sync, de and pixel data to the converter inputs, and blanks the converter between frames.
- Waits out the converter latency before reporting frame completion, with an active-size check.
- Sits between the camera/test-pattern sources and the colour-space converter in the vip chain.

Parameters:
- H_ACT, 640: expected de-high pixels per line.
- V_ACT, 480: expected active lines per frame.
- CNT_W, 12: width of the pixel and line counters.
- PIPE_LAT, 3: converter latency in cycles; length of the drain period, ≥1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous reset, active-low.
- src0_req, in, 1: source 0 requests a frame (level).
- src0_vsync, in, 1: source 0 vsync (active high).
- src0_hsync, in, 1: source 0 hsync.
- src0_de, in, 1: source 0 data enable.
- src0_data, in, 16: source 0 RGB565 as {R[15:11], G[10:5], B[4:0]}.
- src1_req, src1_vsync, src1_hsync, src1_de, src1_data: same as source 0.
- grant, out, 2: one-hot current grant; 0 when idle.
- busy, out, 1: high in any state other than IDLE.
- out_vsync, out_hsync, out_de, out, 1 each: to converter pre_frame_*.
- out_red, out, 5: to converter.
- out_green, out, 6: to converter.
- out_blue, out, 5: to converter.
- frame_done, out, 1: single-cycle pulse when the frame has cleared the converter.
- frame_err, out, 1: size error for the frame just completed; valid with frame_done, held until the next frame_done.
- frame_src, out, 1: index of the source of the completed frame; valid with frame_done, held.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs, counters and per-source vsync delay regs = 0. last_grant = 1, so source 0 wins the first tie.
- Edge detection uses a 1-cycle registered copy of each source vsync.
  - SOF = vsync_d=1 & vsync=0.
  - EOF = vsync_d=0 & vsync=1.
- States:
  - IDLE:
    - If exactly one req is high, select that source.
    - If both are high, select !last_grant.
    - On a selection, latch sel, drive grant, go to WAIT_SOF.
    - Otherwise stay in IDLE.
  - WAIT_SOF:
    - If the selected req drops, go to IDLE, grant=0, last_grant unchanged.
    - On SOF of the selected source, go to ACTIVE; the SOF-cycle sample is passed.
    - If the req drop and SOF occur in the same cycle, SOF wins.
  - ACTIVE:
    - Pass the selected source every cycle.
    - req is ignored; the frame always completes.
    - On EOF, pass that sample too and go to DRAIN.
  - DRAIN:
    - Output registers are loaded with 0.
    - drain_cnt runs 0..PIPE_LAT-1.
    - At PIPE_LAT-1: go to IDLE, last_grant=sel, grant=0, and register frame_done=1 for one cycle (visible in the first IDLE cycle).
    - IDLE may issue a new grant in that same cycle.
- Output path:
  - Output registers (sync, de, data) load the selected source's inputs in ACTIVE and in the SOF cycle of WAIT_SOF; otherwise they load 0.
  - Latency source→out = 1 cycle.
  - The unselected source never reaches the outputs.
  - Data split: red=data[15:11], green=data[10:5], blue=data[4:0].
- Size check (passed samples only):
  - pix_cnt increments on each de=1 sample.
  - On a de falling edge:
    - err is set if pix_cnt≠H_ACT.
    - line_cnt increments.
    - pix_cnt is cleared.
  - Counters saturate at 2^CNT_W-1.
  - At EOF:
    - err is set if line_cnt≠V_ACT, or if de=1 on the EOF sample.
  - frame_err is loaded from err when frame_done asserts.
  - Counters and err clear on entry to WAIT_SOF.
- A reset mid-frame returns the block to IDLE immediately with outputs 0, and no frame_done is issued.

Test Plan:
- Source 0 only:
  - Stimulus: src0_req=1, 640x480 frame (4 lines × H_ACT shortened via H_ACT=8, V_ACT=4 in the bench).
  - Required response:
    - grant=01 and out_* equal src0 delayed 1 cycle from SOF through EOF.
    - frame_done exactly PIPE_LAT cycles after the EOF sample appears on out_vsync.
    - frame_err=0, frame_src=0.
- Both requesting continuously:
  - Required response: grants alternate 0,1,0,1 over 4 frames; src1 data never seen while grant=01, and vice versa.
- Wrong line length:
  - Stimulus: H_ACT=8, one line with 7 de cycles.
  - Required response: frame_err=1 at frame_done. The next correct frame gives frame_err=0.
- req drop during WAIT_SOF:
  - Stimulus: src0 drops req before SOF while src1 requests.
  - Required response: returns to IDLE, then src1 is granted; no frame_done and no output activity for src0.
- Extra lines and late de:
  - Stimulus: 5 lines with V_ACT=4 → frame_err=1.
  - Stimulus: de high at the EOF sample → frame_err=1.
- Reset asserted mid-ACTIVE:
  - Required response: all outputs 0 asynchronously; after release, src0 wins the tie when both request.
